// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU control one-hot, flag register, execute-unit FSM states and op decode.
// The decode helper turns a possibly multi-hot control word into a single op by fixed priority.
package cpu_pkg;

  parameter int DATA_WIDTH = 16;

  typedef struct packed {
    logic alu_add;
    logic alu_sub;
    logic alu_cmp;
    logic alu_mul;
    logic alu_div;
    logic alu_mod;
    logic alu_lsl;
    logic alu_lsr;
    logic alu_asr;
    logic alu_or;
    logic alu_and;
    logic alu_not;
    logic alu_mov;
  } aluctrl;

  typedef struct packed {
    logic gt;
    logic et;
  } flg;

  typedef enum logic [1:0] {ALU_IDLE, ALU_MUL, ALU_DIV, ALU_DONE} alu_state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_CMP, OP_MUL, OP_DIV, OP_MOD,
    OP_LSL, OP_LSR, OP_ASR, OP_OR, OP_AND, OP_NOT, OP_MOV
  } alu_op_e;

  function automatic alu_op_e alu_decode(input aluctrl c);
    if (c.alu_add)      return OP_ADD;
    else if (c.alu_sub) return OP_SUB;
    else if (c.alu_cmp) return OP_CMP;
    else if (c.alu_mul) return OP_MUL;
    else if (c.alu_div) return OP_DIV;
    else if (c.alu_mod) return OP_MOD;
    else if (c.alu_lsl) return OP_LSL;
    else if (c.alu_lsr) return OP_LSR;
    else if (c.alu_asr) return OP_ASR;
    else if (c.alu_or)  return OP_OR;
    else if (c.alu_and) return OP_AND;
    else if (c.alu_not) return OP_NOT;
    else if (c.alu_mov) return OP_MOV;
    else                return OP_NOP;
  endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring signed divider: one quotient bit per cycle on magnitudes, sign fix-up on the outputs.
// done is high during the last of W iterations; outputs stay valid until the next start.
module alu_seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dz
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  a_q, dvs_q, quo_q, rem_q;
  logic          qneg_q, rneg_q, dz_q, run_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    rem_sh, rem_sub;
  logic          rem_ge;

  // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
  assign rem_sh  = {rem_q, quo_q[W-1]};
  assign rem_ge  = rem_sh >= {1'b0, dvs_q};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign done    = run_q && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      run_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      a_q    <= dividend;
      dvs_q  <= divisor[W-1] ? -divisor : divisor;
      quo_q  <= dividend[W-1] ? -dividend : dividend;
      rem_q  <= '0;
      qneg_q <= dividend[W-1] ^ divisor[W-1];
      rneg_q <= dividend[W-1];
      dz_q   <= (divisor == '0);
      run_q  <= 1'b1;
      cnt_q  <= '0;
    end else if (run_q) begin
      rem_q <= rem_ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
      quo_q <= {quo_q[W-2:0], rem_ge};
      cnt_q <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

  assign dz        = dz_q;
  assign quotient  = dz_q ? '1  : (qneg_q ? -quo_q : quo_q);
  assign remainder = dz_q ? a_q : (rneg_q ? -rem_q : rem_q);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: simple ops answer next cycle, MUL/DIV/MOD iterate DATA_WIDTH cycles then load.
// Results hold under out_ready=0; new ops are refused until the output slot can drain.
module alu_exec_unit #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int SHW        = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  cpu_pkg::aluctrl       ctrl,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output cpu_pkg::flg           flags,
  output logic                  dz_err,
  output logic                  busy
);
  import cpu_pkg::*;

  alu_state_e                   state_q, state_d;
  alu_op_e                      op, op_q;
  logic                         accept, is_div_op, is_iter;
  logic [SHW-1:0]               sh_amt, cnt_q;
  logic                         sh_big;
  logic signed [DATA_WIDTH-1:0] asr_res;
  logic [DATA_WIDTH-1:0]        simple_res;
  logic [DATA_WIDTH-1:0]        mul_acc_q, mul_mcand_q, mul_mplier_q;
  logic                         div_done, div_dz;
  logic [DATA_WIDTH-1:0]        div_quo, div_rem;

  assign op        = alu_decode(ctrl);
  assign accept    = in_valid && in_ready;
  assign is_div_op = (op == OP_DIV) || (op == OP_MOD);
  assign is_iter   = (op == OP_MUL) || is_div_op;

  assign sh_amt  = op_b[SHW-1:0];
  assign sh_big  = |op_b[DATA_WIDTH-1:SHW];
  assign asr_res = $signed(op_a) >>> sh_amt;

  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD:  simple_res = op_a + op_b;
      OP_SUB:  simple_res = op_a - op_b;
      OP_LSL:  simple_res = sh_big ? '0 : (op_a << sh_amt);
      OP_LSR:  simple_res = sh_big ? '0 : (op_a >> sh_amt);
      OP_ASR:  simple_res = sh_big ? {DATA_WIDTH{op_a[DATA_WIDTH-1]}} : asr_res;
      OP_OR:   simple_res = op_a | op_b;
      OP_AND:  simple_res = op_a & op_b;
      OP_NOT:  simple_res = ~op_b;
      OP_MOV:  simple_res = op_b;
      default: simple_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ALU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ALU_IDLE: if (accept) begin
        if (op == OP_MUL)   state_d = ALU_MUL;
        else if (is_div_op) state_d = ALU_DIV;
      end
      ALU_MUL:  if (cnt_q == SHW'(DATA_WIDTH - 1)) state_d = ALU_DONE;
      ALU_DIV:  if (div_done) state_d = ALU_DONE;
      ALU_DONE: state_d = ALU_IDLE;
      default:  state_d = ALU_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ALU_IDLE) && (!out_valid || out_ready);
    busy     = (state_q != ALU_IDLE);
  end

  // Shift-add multiplier plus the output slot; flags only move on an accepted CMP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_NOP;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      cnt_q        <= '0;
      result       <= '0;
      dz_err       <= 1'b0;
      out_valid    <= 1'b0;
      flags        <= '0;
    end else begin
      if (accept) begin
        op_q         <= op;
        mul_acc_q    <= '0;
        mul_mcand_q  <= op_a;
        mul_mplier_q <= op_b;
        cnt_q        <= '0;
      end else if (state_q == ALU_MUL) begin
        mul_acc_q    <= mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
        mul_mcand_q  <= mul_mcand_q << 1;
        mul_mplier_q <= mul_mplier_q >> 1;
        cnt_q        <= cnt_q + 1'b1;
      end

      if (accept && !is_iter) begin
        result    <= simple_res;
        dz_err    <= 1'b0;
        out_valid <= 1'b1;
        if (op == OP_CMP) flags <= flg'{gt: ($signed(op_a) > $signed(op_b)), et: (op_a == op_b)};
      end else if (state_q == ALU_DONE) begin
        result    <= (op_q == OP_MUL) ? mul_acc_q : ((op_q == OP_MOD) ? div_rem : div_quo);
        dz_err    <= (op_q != OP_MUL) && div_dz;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  alu_seq_divider #(.W(DATA_WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && is_div_op),
    .dividend  (op_a),
    .divisor   (op_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .dz        (div_dz)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_alu_exec_unit;
  import cpu_pkg::*;

  localparam int W = 16;
  localparam int I_ADD = 12, I_SUB = 11, I_CMP = 10, I_MUL = 9, I_DIV = 8, I_MOD = 7;
  localparam int I_LSL = 6, I_LSR = 5, I_ASR = 4, I_OR = 3, I_AND = 2, I_NOT = 1, I_MOV = 0;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, dz_err, busy;
  aluctrl       ctrl;
  logic [W-1:0] op_a, op_b, result;
  flg           flags;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .dz_err(dz_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         dz;
    logic [1:0]   fl;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic aluctrl mk(input int idx);
    logic [$bits(aluctrl)-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return aluctrl'(v);
  endfunction

  // Monitor: every consumed output is matched against the oldest expectation
  exp_t m;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: result 0x%0h with nothing pending", result);
      end else begin
        m = exp_q.pop_front();
        check({m.tag, "_result"}, 32'(result), 32'(m.res));
        check({m.tag, "_dz_err"}, 32'(dz_err), 32'(m.dz));
        check({m.tag, "_flags"},  32'(flags),  32'(m.fl));
      end
    end
  end

  task automatic send(input string tag, input aluctrl c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] er, input logic edz, input logic [1:0] efl, output int acc_cyc);
    exp_t e;
    int   n;
    e.tag = tag; e.res = er; e.dz = edz; e.fl = efl;
    exp_q.push_back(e);
    ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: in_ready still 0 after %0d cycles, expected 1", tag, n);
      in_valid = 1'b0;
      void'(exp_q.pop_back());
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int lat);
    int c;
    bit busy_ok;
    c = 0;
    busy_ok = 1'b1;
    while (!out_valid && c < 60) begin
      busy_ok &= busy;
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, "_latency"}, 32'(c), 32'(lat));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c1, c2, stale;
    logic [1:0] fl;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ctrl = '0; op_a = '0; op_b = '0;
    fl = 2'b00;
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    check("rst_dz_err",    32'(dz_err),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send("add_ovf", mk(I_ADD), 16'h7FFF, 16'h0001, 16'h8000, 1'b0, fl, c1);
    check("add_latency_1", 32'(out_valid), 32'd1);
    send("sub_wrap", mk(I_SUB), 16'h0000, 16'h0001, 16'hFFFF, 1'b0, fl, c2);
    check("no_bubble", 32'(c2 - c1), 32'd1);

    send("mul", mk(I_MUL), 16'h0123, 16'h0045, 16'h4E6F, 1'b0, fl, c1);
    wait_result("mul", W + 1);
    send("div_neg", mk(I_DIV), 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, fl, c1);
    wait_result("div_neg", W + 1);
    send("mod_neg", mk(I_MOD), 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, fl, c1);
    send("div_zero", mk(I_DIV), 16'h1234, 16'h0000, 16'hFFFF, 1'b1, fl, c1);
    wait_result("div_zero", W + 1);
    send("mod_zero", mk(I_MOD), 16'h1234, 16'h0000, 16'h1234, 1'b1, fl, c1);
    send("div_min", mk(I_DIV), 16'h8000, 16'hFFFF, 16'h8000, 1'b0, fl, c1);

    send("cmp_neg", mk(I_CMP), 16'hFFFE, 16'h0001, 16'h0000, 1'b0, 2'b00, c1);
    fl = 2'b01;
    send("cmp_eq", mk(I_CMP), 16'h0005, 16'h0005, 16'h0000, 1'b0, fl, c1);
    send("add_keep", mk(I_ADD), 16'h0005, 16'h0005, 16'h000A, 1'b0, fl, c1);
    send("multihot", aluctrl'(mk(I_ADD) | mk(I_SUB)), 16'h0003, 16'h0001, 16'h0004, 1'b0, fl, c1);
    send("nop", aluctrl'('0), 16'h1111, 16'h2222, 16'h0000, 1'b0, fl, c1);
    send("asr_big", mk(I_ASR), 16'h8000, 16'd20, 16'hFFFF, 1'b0, fl, c1);
    send("asr_4", mk(I_ASR), 16'h8000, 16'd4, 16'hF800, 1'b0, fl, c1);
    send("lsl_big", mk(I_LSL), 16'h1234, 16'd16, 16'h0000, 1'b0, fl, c1);
    send("lsl_15", mk(I_LSL), 16'h0001, 16'd15, 16'h8000, 1'b0, fl, c1);
    send("lsr_15", mk(I_LSR), 16'h8000, 16'd15, 16'h0001, 1'b0, fl, c1);
    send("and", mk(I_AND), 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, fl, c1);
    send("not", mk(I_NOT), 16'h1234, 16'h00FF, 16'hFF00, 1'b0, fl, c1);
    send("mov", mk(I_MOV), 16'h1234, 16'hABCD, 16'hABCD, 1'b0, fl, c1);
    fl = 2'b10;
    send("cmp_gt", mk(I_CMP), 16'h0005, 16'h0003, 16'h0000, 1'b0, fl, c1);
    send("mul_wrap", mk(I_MUL), 16'h0003, 16'hFFFF, 16'hFFFD, 1'b0, fl, c1);

    // Backpressure: the result must sit still and block new ops
    drain();
    out_ready = 1'b0;
    send("or_hold", mk(I_OR), 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, fl, c1);
    for (int i = 0; i < 4; i++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result",    32'(result),    32'h0FF0);
      check("hold_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;

    // Reset in the middle of a divide
    drain();
    send("div_rst", mk(I_DIV), 16'h0064, 16'h0007, 16'h000E, 1'b0, fl, c1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_flags",     32'(flags),     32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
